// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// All outputs decode from registered state, so out_ready never reaches in_ready combinationally.
module pipe_skid_reg #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_count
);

    // Encodings equal the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] main_q, main_next;
    logic [WIDTH-1:0] skid_q, skid_next;
    logic [CNT_W-1:0] cnt_q;
    logic             in_xfer, out_xfer;

    assign in_ready   = (state != FULL);
    assign out_valid  = (state != EMPTY);
    assign occupancy  = state;
    assign data_out   = main_q;
    assign xfer_count = cnt_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (flush) begin
            state_next = EMPTY;
            main_next  = RESET_VALUE;
            skid_next  = RESET_VALUE;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_next  = data_in;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_next = data_in;
                    end else if (in_xfer) begin
                        skid_next  = data_in;
                        state_next = FULL;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // Younger skid entry moves up; in_ready is low so nothing new arrives.
                    if (out_xfer) begin
                        main_next  = skid_q;
                        state_next = BUSY;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
            cnt_q  <= '0;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
            // A transfer completing on a flush edge was consumed downstream, so it counts.
            if (out_xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
